// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS main control FSM. Each instruction takes 2 to 5 clocks from fetch back to fetch.
// Outputs are decoded from the current state and are valid every cycle. There is no handshake and no backpressure.
module mips_multicycle_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic             zero,
  output logic             pc_en,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             alu_op1,
  output logic             alu_op0,
  output logic [1:0]       pc_source,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEMADDR   = 4'd2;
  localparam logic [3:0] S_MEMREAD   = 4'd3;
  localparam logic [3:0] S_MEMWB     = 4'd4;
  localparam logic [3:0] S_MEMWRITE  = 4'd5;
  localparam logic [3:0] S_EXEC      = 4'd6;
  localparam logic [3:0] S_RCOMPLETE = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    ST_FETCH     = S_FETCH,
    ST_DECODE    = S_DECODE,
    ST_MEMADDR   = S_MEMADDR,
    ST_MEMREAD   = S_MEMREAD,
    ST_MEMWB     = S_MEMWB,
    ST_MEMWRITE  = S_MEMWRITE,
    ST_EXEC      = S_EXEC,
    ST_RCOMPLETE = S_RCOMPLETE,
    ST_BRANCH    = S_BRANCH,
    ST_JUMP      = S_JUMP
  } state_t;

  state_t state_r;
  logic   retiring;

  assign state = state_r;

  // Every retiring state returns to fetch, so counting here counts completed instructions only.
  always_comb begin
    retiring = 1'b0;
    case (state_r)
      ST_MEMWB, ST_MEMWRITE, ST_RCOMPLETE, ST_BRANCH, ST_JUMP: retiring = 1'b1;
      default: retiring = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_FETCH;
      instr_count <= '0;
    end else begin
      case (state_r)
        ST_FETCH: state_r <= ST_DECODE;
        ST_DECODE: begin
          case (op)
            OP_LW, OP_SW: state_r <= ST_MEMADDR;
            OP_RTYPE:     state_r <= ST_EXEC;
            OP_BEQ:       state_r <= ST_BRANCH;
            OP_J:         state_r <= ST_JUMP;
            default:      state_r <= ST_FETCH;
          endcase
        end
        ST_MEMADDR:   state_r <= (op == OP_LW) ? ST_MEMREAD : ST_MEMWRITE;
        ST_MEMREAD:   state_r <= ST_MEMWB;
        ST_MEMWB:     state_r <= ST_FETCH;
        ST_MEMWRITE:  state_r <= ST_FETCH;
        ST_EXEC:      state_r <= ST_RCOMPLETE;
        ST_RCOMPLETE: state_r <= ST_FETCH;
        ST_BRANCH:    state_r <= ST_FETCH;
        ST_JUMP:      state_r <= ST_FETCH;
        default:      state_r <= ST_FETCH;
      endcase
      if (retiring) instr_count <= instr_count + CNT_W'(1);
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op1       = 1'b0;
    alu_op0       = 1'b0;
    pc_source     = 2'b00;
    illegal_op    = 1'b0;
    case (state_r)
      ST_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = 1'b1;
      end
      ST_DECODE: begin
        alu_src_b = 2'b11;
        case (op)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J: illegal_op = 1'b0;
          default:                              illegal_op = 1'b1;
        endcase
      end
      ST_MEMADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ST_MEMREAD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      ST_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_MEMWRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      ST_EXEC: begin
        alu_src_a = 1'b1;
        alu_op1   = 1'b1;
      end
      ST_RCOMPLETE: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op0       = 1'b1;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      ST_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      default: ;
    endcase
  end

  assign pc_en = pc_write | (pc_write_cond & zero);

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
Main control FSM for the multi-cycle MIPS datapath. It decodes the 6-bit opcode and sequences fetch, decode, execute, memory and writeback one step per clock. It drives the ALUOp1/ALUOp0 pair into the ALU control decoder, all datapath mux selects and write enables. It also keeps a retired-instruction counter for lab benches.

Parameters:
CNT_W, 16, width of the retired-instruction counter
S_FETCH..S_JUMP, 0..9, state encodings (localparam, 4 bits)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
op  in  6  opcode field of the instruction register (IR[31:26])
zero  in  1  ALU zero flag
pc_en  out  1  PC load enable = pc_write | (pc_write_cond & zero)
pc_write  out  1  unconditional PC write
pc_write_cond  out  1  branch-conditional PC write
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  instruction register load
mem_to_reg  out  1  register write data select: 1 = MDR
reg_dst  out  1  destination register select: 1 = rd, 0 = rt
reg_write  out  1  register file write enable
alu_src_a  out  1  ALU A select: 0 = PC, 1 = register A
alu_src_b  out  2  ALU B select: 00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
alu_op1  out  1  ALUOp1 to the ALU control decoder
alu_op0  out  1  ALUOp0 to the ALU control decoder
pc_source  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target
illegal_op  out  1  one-cycle pulse: unrecognised opcode
instr_count  out  CNT_W  retired-instruction count
state  out  4  current state, for debug

Behaviour:
- Clocking and reset: one clock. Reset is synchronous, active-high. On a rising edge with reset=1: state <= S_FETCH and instr_count <= 0. Reset has priority over every other event, including mid-instruction; an aborted instruction is not counted.
- Outputs are Moore, decoded combinationally from the registered state. The one exception is pc_en, which also uses zero.
- Any output not listed for a state is 0. After reset, outputs therefore take the S_FETCH values.
- S_FETCH (0): mem_read=1, ir_write=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00, pc_write=1. Next state S_DECODE.
- S_DECODE (1): alu_src_a=0, alu_src_b=11, alu_op=00. Next state by op:
  - 100011 (lw) or 101011 (sw): S_MEMADDR
  - 000000 (R-type): S_EXEC
  - 000100 (beq): S_BRANCH
  - 000010 (j): S_JUMP
  - any other op: illegal_op=1 for this cycle, next state S_FETCH, not counted.
- S_MEMADDR (2): alu_src_a=1, alu_src_b=10, alu_op=00. Next state is S_MEMREAD for lw, S_MEMWRITE for sw. op is sampled in this state; IR is held because ir_write=0.
- S_MEMREAD (3): mem_read=1, iord=1. Next state S_MEMWB.
- S_MEMWB (4): reg_write=1, mem_to_reg=1, reg_dst=0. Next state S_FETCH; retires.
- S_MEMWRITE (5): mem_write=1, iord=1. Next state S_FETCH; retires.
- S_EXEC (6): alu_src_a=1, alu_src_b=00, alu_op=10. Next state S_RCOMPLETE.
- S_RCOMPLETE (7): reg_write=1, reg_dst=1, mem_to_reg=0. Next state S_FETCH; retires.
- S_BRANCH (8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. pc_en equals zero. Next state S_FETCH; retires whether taken or not.
- S_JUMP (9): pc_write=1, pc_source=10. Next state S_FETCH; retires.
- Unused encodings 10-15: all outputs 0, next state S_FETCH.
- Latency in clocks from the S_FETCH edge back to S_FETCH: lw 5, sw 4, R-type 4, beq 3, j 3, illegal 2.
- instr_count increments by 1 on the edge leaving any retiring state. It wraps from 2^CNT_W-1 to 0 silently.
- mem_read and mem_write are never both 1. reg_write and pc_write are never both 1.

Test Plan:
- Reset held 2 clocks, then released with op=100011 (lw) -> states 0,1,2,3,4,0. mem_read=1 in states 0 and 3; reg_write=1 and mem_to_reg=1 only in state 4; instr_count=1.
- op=000000 (R-type) -> states 0,1,6,7,0. alu_op1=1, alu_op0=0 only in state 6; reg_dst=1 in state 7; 4 clocks total.
- op=000100 (beq), run once with zero=1 and once with zero=0 -> in state 8, alu_op=01 and pc_en equals zero. Both runs retire: instr_count +2.
- op=101011 (sw), then op=000010 (j) -> sw states 0,1,2,5,0 with mem_write=1 only in state 5. j states 0,1,9,0 with pc_source=10 and pc_en=1.
- op=111111 -> illegal_op pulses for 1 cycle in state 1, FSM returns to state 0, instr_count unchanged.
- Reset asserted while in state 3 of a lw -> next state 0, instr_count=0. With CNT_W=2, executing 5 j instructions -> instr_count wraps to 1.
